binary_to_bcd: RTL and testbench

BINARY_TO_BCD -- requirements
Module: binary_to_bcd

---
 rtl/binary_to_bcd.sv | 158 +++++++++++++++
 tb/tb_binary_to_bcd.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/binary_to_bcd.sv
// rtl/binary_to_bcd.sv - sequential double-dabble binary to 4-digit packed BCD converter
//
// Purpose:
//   Converts an unsigned BIN_W-bit operand to four packed BCD digits, one
//   double-dabble step per clock. Operands above 9999 saturate the display
//   value to 16'h9999 and raise ovf. The result registers only change when a
//   conversion completes or on reset, so a downstream display stays stable.
//
// Timing (edge 0 is the edge that accepts start):
//   edges 1..BIN_W   one shift/adjust step each; the last one also loads the
//                    result and enters DONE
//   edge BIN_W+1     DONE -> IDLE (start ignored here)
//   edge BIN_W+2     earliest next accept, so a held start repeats every
//                    BIN_W+2 cycles
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   conversion request, honoured only while idle
//   bin_in   in   BIN_W-bit unsigned operand, sampled at the accepting edge
//   bcd_out  out  16-bit packed BCD result, [15:12] thousands .. [3:0] units
//   busy     out  high from the accepting edge until the return to idle
//   done     out  one-cycle pulse, high while bcd_out holds a fresh result
//   ovf      out  the operand of the last completed conversion exceeded 9999

module binary_to_bcd #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic [15:0]      bcd_out,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  // Five nibbles hold any 16-bit operand (max 65535) without losing a carry.
  localparam int SCR_W  = 20;
  localparam int NIBS   = SCR_W / 4;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q,    state_d;
  logic [BIN_W-1:0]   op_q,       op_d;
  logic [SCR_W-1:0]   scr_q,      scr_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [15:0]        bcd_q,      bcd_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;
  logic               ovf_q,      ovf_d;

  logic [SCR_W-1:0]   scr_adj;
  logic [SCR_W-1:0]   scr_step;
  logic [BIN_W-1:0]   op_step;

  // One double-dabble step: bias every nibble >= 5 by 3 so the following
  // shift carries correctly into the next decimal digit, then shift the
  // operand MSB into the scratch LSB.
  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < NIBS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
    scr_step = {scr_adj[SCR_W-2:0], op_q[BIN_W-1]};
    op_step  = {op_q[BIN_W-2:0], 1'b0};
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d       = bin_in;
          scr_d      = '0;
          cnt_d      = CNT_LOAD;
          ovf_pend_d = (32'(bin_in) > 32'd9999);
          busy_d     = 1'b1;
          state_d    = S_CONV;
        end
      end

      S_CONV: begin
        op_d  = op_step;
        scr_d = scr_step;
        cnt_d = cnt_q - CNT_LAST;
        // The final step publishes its own result directly so that done and
        // the new bcd_out appear in the same cycle.
        if (cnt_q == CNT_LAST) begin
          bcd_d   = ovf_pend_q ? 16'h9999 : scr_step[15:0];
          ovf_d   = ovf_pend_q;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= 16'h0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bcd_out = bcd_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_binary_to_bcd.sv
// tb/tb_binary_to_bcd.sv - self-checking bench for binary_to_bcd with BIN_W=14
//
// Observation index k counts negedge samples after the accepting edge:
// k=0 follows edge 0, k=14 follows the final step (done high), k=15 is idle.

module tb_binary_to_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin_in;
  logic [15:0] bcd_out;
  logic        busy;
  logic        done;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  binary_to_bcd #(.BIN_W(14)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .bcd_out (bcd_out),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf)
  );

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Decimal reference built from division, saturating above 9999.
  function automatic logic [15:0] ref_bcd(input int v);
    if (v > 9999) return 16'h9999;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Starts one conversion of v and follows it through k=0..15. inj[k] set
  // drives start=1 with bin_in=42 after sample k (must be ignored); otherwise
  // bin_in is scrambled after acceptance to show it is not resampled.
  task automatic run_conv(input logic [13:0] v, input logic [15:0] inj,
                          output logic [15:0] r_bcd, output logic r_ovf,
                          output int n_done, output int k_done, output logic busy_ok);
    start  = 1'b1;
    bin_in = v;
    tick();
    n_done  = 0;
    k_done  = -1;
    busy_ok = 1'b1;
    r_bcd   = 16'h0;
    r_ovf   = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (busy !== (k < 15)) busy_ok = 1'b0;
      if (done === 1'b1) begin
        n_done++;
        k_done = k;
        r_bcd  = bcd_out;
        r_ovf  = ovf;
      end
      if (k < 15) begin
        start  = inj[k];
        bin_in = inj[k] ? 14'd42 : ~v;
        tick();
      end
    end
    start = 1'b0;
  endtask

  task automatic conv_check(input string name, input logic [13:0] v, input logic [15:0] inj,
                            input logic [15:0] exp_bcd, input logic exp_ovf);
    logic [15:0] r_bcd;
    logic        r_ovf;
    int          n_done;
    int          k_done;
    logic        busy_ok;
    run_conv(v, inj, r_bcd, r_ovf, n_done, k_done, busy_ok);
    check({name, "_bcd"},     32'(r_bcd),   32'(exp_bcd));
    check({name, "_ovf"},     32'(r_ovf),   32'(exp_ovf));
    check({name, "_ndone"},   32'(n_done),  32'd1);
    check({name, "_kdone"},   32'(k_done),  32'd14);
    check({name, "_busy"},    32'(busy_ok), 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    logic [15:0] r_bcd;
    logic        r_ovf;
    int          n_done;
    int          k_done;
    logic        busy_ok;
    int          dn;
    int          dk[2];
    logic [15:0] db[2];
    int          extra[4];

    vecs[0] = '{14'd1234,  16'h1234, 1'b0};
    vecs[1] = '{14'd0,     16'h0000, 1'b0};
    vecs[2] = '{14'd9999,  16'h9999, 1'b0};
    vecs[3] = '{14'd7,     16'h0007, 1'b0};
    vecs[4] = '{14'd10,    16'h0010, 1'b0};
    vecs[5] = '{14'd10000, 16'h9999, 1'b1};
    vecs[6] = '{14'd16383, 16'h9999, 1'b1};
    vecs[7] = '{14'd42,    16'h0042, 1'b0};

    rst    = 1'b1;
    start  = 1'b0;
    bin_in = 14'd0;
    tick();
    tick();
    check("reset_bcd",  32'(bcd_out), 32'h0);
    check("reset_busy", 32'(busy),    32'h0);
    check("reset_done", 32'(done),    32'h0);
    check("reset_ovf",  32'(ovf),     32'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      conv_check($sformatf("vec%0d_%0d", i, vecs[i].bin), vecs[i].bin, 16'h0,
                 vecs[i].bcd, vecs[i].ovf);
    end

    // Held start: operand changes after acceptance; second run starts at edge 16.
    start  = 1'b1;
    bin_in = 14'd5;
    tick();
    dn = 0;
    dk[0] = -1; dk[1] = -1;
    db[0] = 16'h0; db[1] = 16'h0;
    for (int k = 0; k < 32; k++) begin
      if (done === 1'b1) begin
        if (dn < 2) begin
          dk[dn] = k;
          db[dn] = bcd_out;
        end
        dn++;
      end
      if (k == 15) check("b2b_busy_k15", 32'(busy), 32'h0);
      if (k == 16) check("b2b_busy_k16", 32'(busy), 32'h1);
      if (k == 2)  bin_in = 14'd6;
      if (k == 30) start = 1'b0;
      if (k < 31) tick();
    end
    check("b2b_ndone", 32'(dn),    32'd2);
    check("b2b_k0",    32'(dk[0]), 32'd14);
    check("b2b_bcd0",  32'(db[0]), 32'h0005);
    check("b2b_k1",    32'(dk[1]), 32'd30);
    check("b2b_bcd1",  32'(db[1]), 32'h0006);

    // Reset in the middle of a 1234 conversion, previous result was 0006.
    start  = 1'b1;
    bin_in = 14'd1234;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    rst = 1'b1;
    tick();
    check("midrst_busy", 32'(busy),    32'h0);
    check("midrst_done", 32'(done),    32'h0);
    check("midrst_bcd",  32'(bcd_out), 32'h0);
    check("midrst_ovf",  32'(ovf),     32'h0);
    rst = 1'b0;
    conv_check("midrst_restart", 14'd1234, 16'h0, 16'h1234, 1'b0);

    // Start pulses while busy, including the DONE cycle, must not queue.
    conv_check("ignore_start", 14'd1234, 16'h4021, 16'h1234, 1'b0);
    tick();
    check("ignore_busy_after", 32'(busy),    32'h0);
    check("ignore_done_after", 32'(done),    32'h0);
    check("ignore_bcd_hold",   32'(bcd_out), 32'h1234);

    // Reference sweep across the 14-bit range, plus the decimal boundaries.
    for (int v = 0; v < 16384; v += 5) begin
      run_conv(14'(v), 16'h0, r_bcd, r_ovf, n_done, k_done, busy_ok);
      check($sformatf("sweep_%0d", v), {7'd0, r_ovf, r_bcd, 8'(n_done)},
            {7'd0, (v > 9999) ? 1'b1 : 1'b0, ref_bcd(v), 8'd1});
    end
    extra[0] = 9998; extra[1] = 9999; extra[2] = 10001; extra[3] = 16383;
    for (int i = 0; i < 4; i++) begin
      run_conv(14'(extra[i]), 16'h0, r_bcd, r_ovf, n_done, k_done, busy_ok);
      check($sformatf("edge_%0d", extra[i]), {7'd0, r_ovf, r_bcd, 8'(n_done)},
            {7'd0, (extra[i] > 9999) ? 1'b1 : 1'b0, ref_bcd(extra[i]), 8'd1});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
